pulse_event_throttle: RTL and testbench
=======================================

Name: pulse_event_throttle

Overview:
- Fast-domain (clk_f) stage directly upstream of the 1-bit pulse handshake synchronizer.
- Accepts single-cycle event pulses at any rate and counts pending events in a saturating counter.
- Re-issues events one at a time as single-cycle pulses, spaced by at least GAP_CYCLES clk_f cycles, so the downstream handshake never merges two events.
- Reports backlog, activity and sticky overflow to software/status logic.

Parameters:
- CNT_W, 4: width of the pending-event counter; max backlog is 2^CNT_W-1.
- GAP_CYCLES, 16: minimum clk_f edges between consecutive pulse_out rising edges.
  - Must be ≥2.
  - Integrator sets it ≥ full handshake round trip: 4×ceil(T_clk_s/T_clk_f)+4.
- GAP_W (localparam), $clog2(GAP_CYCLES+1): gap timer width.

Ports:
- clk_f, input, 1: fast clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- evt_in, input, 1: event strobe; each high cycle is one event.
- clr, input, 1: synchronous clear of backlog and overflow.
- pulse_out, input→output, 1: registered single-cycle pulse; drives the synchronizer's data_in.
- pending, output, CNT_W: current backlog count.
- busy, output, 1: high while pulse_out=1 or gap timer running.
- overflow, output, 1: sticky; an event was dropped at saturation.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pending=0, pulse_out=0, busy=0, overflow=0, gap_cnt=0.
- States: IDLE, GAP.
- pulse_out is set in either of two cases; in both, gap_cnt←GAP_CYCLES-2 and state←GAP:
  - IDLE with pending≠0.
  - GAP with gap_cnt==0 and pending≠0.
- In GAP:
  - gap_cnt≠0: decrement gap_cnt, pulse_out←0.
  - gap_cnt==0 and pending==0: go to IDLE, pulse_out←0.
- Spacing: consecutive pulse_out rising edges are exactly GAP_CYCLES edges apart under continuous backlog, never fewer.
- pulse_out is never high on two consecutive cycles.
- Latency from empty/IDLE: evt_in sampled at edge k makes pending=1 after edge k. pulse_out rises at edge k+1 (high during cycle k+1..k+2). No combinational bypass.
- pending update per edge: +1 on evt_in, -1 on emit.
  - Both in the same edge: pending unchanged.
  - Emit only ever occurs when pending≠0, so there is no underflow.
- Saturation: evt_in with pending==2^CNT_W-1 and no emit that edge leaves pending unchanged, drops the event and sets overflow=1.
  - With emit the same edge, pending stays max and no overflow is raised.
- overflow stays set until clr or reset.
- clr (priority over evt_in):
  - pending←0, overflow←0; an evt_in in the same cycle is discarded.
  - State, gap_cnt and pulse_out continue unaffected; an in-flight gap still completes to protect the downstream handshake.
  - clr in the same edge as an emit condition suppresses that emit.
- busy = pulse_out | (state==GAP); registered-equivalent, glitch-free.
- Reset mid-GAP or mid-pulse: immediate return to the reset values. The downstream block is reset by the same rst_n.
- All outputs are driven directly from flops.

Decomposition:
- Shared package cdc_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_GAP=1'b1;
  - default GAP_CYCLES;
  - the round-trip sizing formula constant/function.
- A small submodule, sat_updown_cnt (param W; inputs inc, dec, clr; outputs cnt, sat_hit), is natural and reusable. The FSM and gap timer stay in the top.

Test Plan:
- Single evt_in pulse at edge 10, GAP_CYCLES=16 → pending=1 after edge 10, pulse_out high only in cycle after edge 11, pending=0 after edge 11, busy low after edge 27.
- 3 back-to-back evt_in at edges 10-12 → pending peaks at 2; pulse_out rises at edges 11, 27, 43; exactly 3 pulses; overflow=0.
- CNT_W=2, 6 evt_in in consecutive cycles from IDLE → pending saturates at 3, emit at first eligible edge; total pulses =5, overflow=1 after the dropped event; clr then gives pending=0, overflow=0.
- evt_in coincident with emit edge while pending=1 → pending stays 1, next pulse GAP_CYCLES edges later.
- clr asserted mid-GAP with pending=4 → pending=0, no further pulses, busy stays high until the gap expires, then IDLE.
- rst_n deasserted mid-GAP with pending=3 → all outputs 0 asynchronously; after release, no pulse until new evt_in.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants for the fast-domain pulse throttle and its handshake synchronizer.
// Holds the FSM state encoding, the default gap and the round-trip sizing helper.
package cdc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_GAP  = 1'b1
    } state_e;

    localparam int unsigned GAP_CYCLES_DEF = 16;

    // Minimum safe gap for a handshake round trip; ratio_ceil = ceil(T_clk_s / T_clk_f).
    function automatic int unsigned gap_cycles_for(input int unsigned ratio_ceil);
        return 4 * ratio_ceil + 4;
    endfunction

endpackage

// File: rtl/pulse_event_throttle_if.sv
// Event/status bundle between the throttle and its producer/status logic.
interface pulse_event_throttle_if #(
    parameter int unsigned CNT_W = 4
);
    logic             evt_in;
    logic             clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             overflow;

    modport master (
        output evt_in, clr,
        input  pulse_out, pending, busy, overflow
    );

    modport slave (
        input  evt_in, clr,
        output pulse_out, pending, busy, overflow
    );
endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with synchronous clear; sat_hit_c flags an increment lost at max.
module sat_updown_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_f,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat_hit_c
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_d, cnt_q;

    // Simultaneous inc and dec cancel, so a full counter with a concurrent dec never saturates.
    always_comb begin
        cnt_d     = cnt_q;
        sat_hit_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == CNT_MAX) begin
                sat_hit_c = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else if (dec && !inc) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pulse_event_throttle.sv
// Buffers incoming event strobes and re-issues them as single-cycle pulses spaced
// GAP_CYCLES apart, so the downstream pulse handshake never merges two events.
module pulse_event_throttle
    import cdc_pkg::*;
#(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                   clk_f,
    input  logic                   rst_n,
    pulse_event_throttle_if.slave  bus
);
    localparam int unsigned        GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYCLES - 2);

    state_e             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               pulse_out_q, pulse_out_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   pending;
    logic               emit_c;
    logic               sat_hit_c;

    // Emit whenever backlog exists and the previous pulse plus its gap are over.
    assign emit_c = !bus.clr && (pending != '0) && !pulse_out_q &&
                    ((state_q == ST_IDLE) || (gap_cnt_q == '0));

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_pending (
        .clk_f     (clk_f),
        .rst_n     (rst_n),
        .inc       (bus.evt_in),
        .dec       (emit_c),
        .clr       (bus.clr),
        .cnt       (pending),
        .sat_hit_c (sat_hit_c)
    );

    // The cycle pulse_out is high counts toward the gap, so the counter holds there.
    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        pulse_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (emit_c) begin
                    pulse_out_d = 1'b1;
                    gap_cnt_d   = GAP_LOAD;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!pulse_out_q) begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end else if (emit_c) begin
                        pulse_out_d = 1'b1;
                        gap_cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        busy_d     = pulse_out_d | (state_d == ST_GAP);
        overflow_d = bus.clr ? 1'b0 : (overflow_q | sat_hit_c);
    end

    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            pulse_out_q <= pulse_out_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.pulse_out = pulse_out_q;
    assign bus.pending   = pending;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pulse_event_throttle.sv
// Two throttle instances (CNT_W=4/GAP=16 and CNT_W=2/GAP=4) driven with shared directed
// and random stimulus, each compared every cycle against an edge-level event model.
module tb_pulse_event_throttle;

    logic clk_f = 1'b0;
    logic rst_n = 1'b0;
    logic evt;
    logic clr;

    always #5 clk_f = ~clk_f;

    pulse_event_throttle_if #(.CNT_W(4)) if0 ();
    pulse_event_throttle_if #(.CNT_W(2)) if1 ();

    assign if0.evt_in = evt;
    assign if0.clr    = clr;
    assign if1.evt_in = evt;
    assign if1.clr    = clr;

    pulse_event_throttle #(.CNT_W(4), .GAP_CYCLES(16)) dut0 (
        .clk_f (clk_f),
        .rst_n (rst_n),
        .bus   (if0)
    );

    pulse_event_throttle #(.CNT_W(2), .GAP_CYCLES(4)) dut1 (
        .clk_f (clk_f),
        .rst_n (rst_n),
        .bus   (if1)
    );

    int checks = 0;
    int errors = 0;

    // Model: pending events, time of the last emitted pulse, sticky overflow.
    int m_max [2] = '{15, 3};
    int m_gap [2] = '{16, 4};
    int m_pend[2];
    int m_last[2];
    bit m_has [2];
    bit m_ovf [2];
    bit m_pulse[2];
    bit m_busy [2];
    int n_edge = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n_edge, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i]  = 0;
            m_last[i]  = 0;
            m_has[i]   = 1'b0;
            m_ovf[i]   = 1'b0;
            m_pulse[i] = 1'b0;
            m_busy[i]  = 1'b0;
        end
    endfunction

    // One clock edge: a pulse may leave once GAP edges have passed since the last one.
    function automatic void model_step(input int i, input bit e, input bit c);
        bit emit;
        emit = !c && (m_pend[i] > 0) && (!m_has[i] || (n_edge - m_last[i] >= m_gap[i]));
        if (c) begin
            m_pend[i] = 0;
            m_ovf[i]  = 1'b0;
        end else if (e && !emit) begin
            if (m_pend[i] == m_max[i]) m_ovf[i] = 1'b1;
            else                       m_pend[i]++;
        end else if (emit && !e) begin
            m_pend[i]--;
        end
        if (emit) begin
            m_has[i]  = 1'b1;
            m_last[i] = n_edge;
        end
        m_pulse[i] = emit;
        m_busy[i]  = emit || (m_has[i] && (n_edge - m_last[i] < m_gap[i]));
    endfunction

    task automatic check_all(input string when);
        chk({when, " d0.pulse_out"}, 32'(if0.pulse_out), 32'(m_pulse[0]));
        chk({when, " d0.pending"},   32'(if0.pending),   32'(m_pend[0]));
        chk({when, " d0.busy"},      32'(if0.busy),      32'(m_busy[0]));
        chk({when, " d0.overflow"},  32'(if0.overflow),  32'(m_ovf[0]));
        chk({when, " d1.pulse_out"}, 32'(if1.pulse_out), 32'(m_pulse[1]));
        chk({when, " d1.pending"},   32'(if1.pending),   32'(m_pend[1]));
        chk({when, " d1.busy"},      32'(if1.busy),      32'(m_busy[1]));
        chk({when, " d1.overflow"},  32'(if1.overflow),  32'(m_ovf[1]));
    endtask

    task automatic step(input bit e, input bit c, input string when);
        @(negedge clk_f);
        evt = e;
        clr = c;
        @(posedge clk_f);
        n_edge++;
        model_step(0, e, c);
        model_step(1, e, c);
        #1;
        check_all(when);
    endtask

    task automatic idle(input int n, input string when);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, when);
    endtask

    initial begin
        int rate;
        evt = 1'b0;
        clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_f);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        idle(5, "idle");

        step(1'b1, 1'b0, "single");
        idle(30, "single");

        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, "burst3");
        idle(50, "burst3");

        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, "sat");
        idle(5, "sat");
        step(1'b0, 1'b1, "sat_clr");
        idle(20, "sat_clr");

        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, "clr_gap");
        idle(3, "clr_gap");
        step(1'b1, 1'b1, "clr_gap_clr");
        idle(20, "clr_gap");

        // Pulse on the last step of a pending=1 stretch while a new event arrives.
        step(1'b1, 1'b0, "coincide");
        idle(15, "coincide");
        step(1'b1, 1'b0, "coincide");
        idle(20, "coincide");

        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, "rst_gap");
        idle(2, "rst_gap");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk_f);
        @(posedge clk_f);
        #1;
        check_all("in_rst");
        rst_n = 1'b1;
        idle(20, "post_rst");

        for (int k = 0; k < 900; k++) begin
            if (k % 100 == 0) rate = (k / 100) % 3 == 0 ? 10 : ((k / 100) % 3 == 1 ? 50 : 90);
            step($urandom_range(0, 99) < rate, $urandom_range(0, 99) < 2, "random");
        end
        idle(40, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
